dlsc_pcie_s6_outbound_trans: RTL
================================

Name: dlsc_pcie_s6_outbound_trans

Overview:
Parametrised outbound address translator for the Spartan-6 PCIe outbound path. It replaces the single-cycle pass-through translator in the outbound top level. It maps AXI-side addresses to 64-bit PCIe addresses through WINDOWS programmable windows, using the existing trans_req/trans_ack handshake of the outbound TLP builder. A simple register port programs the windows and reads them back, and unmatched addresses are either passed through or flagged as errors.

Parameters:
ADDR, 32, AXI address width; 3 ≤ ADDR ≤ 32.
WINDOWS, 4, number of translation windows; 1..16.
WINB, 2, width of the window index; equals clog2(WINDOWS), minimum 1.
PASSTHRU, 0, 1 = unmatched addresses pass through untranslated; 0 = unmatched addresses return an error.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_ready  out  1  config port can accept an access
cfg_valid  in  1  config access request
cfg_write  in  1  1 = write, 0 = read
cfg_win  in  WINB  window index
cfg_reg  in  3  register select: 0 base, 1 mask, 2 target lo, 3 target hi, 4 ctrl
cfg_wdata  in  32  write data
cfg_rvalid  out  1  read data valid (one-cycle pulse)
cfg_rdata  out  32  read data
trans_req  in  1  translation request; held high until trans_ack
trans_req_addr  in  ADDR-2  request address, bits [ADDR-1:2]
trans_ack  out  1  translation complete (one-cycle pulse)
trans_ack_addr  out  62  translated address, bits [63:2]
trans_ack_64  out  1  translated address needs 64-bit TLP format
trans_ack_err  out  1  no window matched and PASSTHRU=0
busy  out  1  translation in flight

Behaviour:
- Reset (rst_n low, asynchronous): every window is disabled and all its registers are 0. All outputs are 0 except cfg_ready=1. The pipeline is cleared. Reset taken mid-translation discards that translation, and no trans_ack is issued for it.
- Per-window registers:
  - base[ADDR-1:2]: cfg_wdata[ADDR-1:2] is stored; bits [1:0] and bits above ADDR are ignored and read as 0.
  - mask[ADDR-1:2]: a 1 bit marks a compared bit.
  - tgt[63:2]: target lo supplies tgt[31:2]; target hi supplies tgt[63:32].
  - ctrl: bit0 = enable.
  - Unused bits read back as 0.
- Config handshake:
  - An access is accepted when cfg_valid && cfg_ready.
  - A write updates the register at the next clock edge.
  - A read drives cfg_rdata with cfg_rvalid=1 exactly one cycle after acceptance.
  - cfg_ready=0 whenever busy=1, so windows are stable during a lookup.
  - cfg_win ≥ WINDOWS: a write is ignored; a read returns 0.
  - cfg_reg values 5..7: a write is ignored; a read returns 0.
- Translation pipeline (3 states: IDLE → CMP → ACK → IDLE):
  - IDLE: when trans_req=1 and no config access is being accepted in the same cycle, capture trans_req_addr, set busy=1, go to CMP. A config access and a request arriving in the same cycle: the config access wins, and the request is taken on the next cycle.
  - CMP: compute hit[i] = enable[i] && (((addr ^ base[i]) & mask[i]) == 0) for every window and register the hit vector.
  - ACK: the lowest-index hit wins and is registered onto the outputs; trans_ack pulses in the following cycle. Latency from request capture to trans_ack is 3 cycles.
  - On the trans_ack cycle busy drops to 0 and the state returns to IDLE. A new request can be captured on the cycle after trans_ack. trans_req still high on that cycle is treated as a new request, so the requester must drop it after trans_ack.
- Output address on a hit:
  - trans_ack_addr[63:ADDR] = tgt[63:ADDR].
  - trans_ack_addr[ADDR-1:2] = (tgt & mask) | (addr & ~mask).
  - trans_ack_64 = 1 when trans_ack_addr[63:32] ≠ 0.
  - trans_ack_err = 0.
- Output on a miss:
  - PASSTHRU=1: trans_ack_addr = zero-extended addr, trans_ack_64=0, trans_ack_err=0.
  - PASSTHRU=0: trans_ack_addr=0, trans_ack_64=0, trans_ack_err=1.
- trans_ack_addr, trans_ack_64 and trans_ack_err are valid only while trans_ack=1; otherwise they hold their last values.
- A mask of all zeros matches every address, giving a catch-all window.

Test Plan:
1. Reset, then read every register of window 0 → cfg_rdata=0 for each. Issue trans_req with addr 0x1000 (bits [31:2]=0x400), PASSTHRU=0 → trans_ack 3 cycles after capture, trans_ack_err=1, trans_ack_addr=0.
2. Window 1: base 0x4000_0000, mask 0xF000_0000, tgt hi 0x0000_0001, tgt lo 0x8000_0000, enable. Request addr 0x4123_4568 → trans_ack_addr = 0x1_8123_4568 >> 2, trans_ack_64=1, trans_ack_err=0.
3. Windows 0 and 2 both match 0x2000_0000, with tgt 0x1000_0000 and 0x3000_0000 respectively → result uses window 0: 0x1000_0000, trans_ack_64=0.
4. Disable window 0 via ctrl=0 and repeat scenario 3 → window 2 wins: 0x3000_0000. With PASSTHRU=1 and all windows disabled → result equals the request address, trans_ack_err=0.
5. Assert cfg_valid in the same cycle as trans_req → config access accepted first, request captured next cycle. During busy=1, cfg_ready=0 and a held write is applied only after trans_ack.
6. Drop rst_n while in CMP → busy=0 and trans_ack never pulses. Read window 1 base after reset → 0.

Source files
------------

// File: rtl/dlsc_pcie_s6_outbound_trans.sv
// Outbound AXI-to-PCIe address translator: WINDOWS programmable base/mask/target
// windows, looked up through a 3-state IDLE/CMP/ACK pipeline on the trans_req/trans_ack handshake.
module dlsc_pcie_s6_outbound_trans #(
  parameter int ADDR     = 32,
  parameter int WINDOWS  = 4,
  parameter int WINB     = 2,
  parameter int PASSTHRU = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            cfg_ready,
  input  logic            cfg_valid,
  input  logic            cfg_write,
  input  logic [WINB-1:0] cfg_win,
  input  logic [2:0]      cfg_reg,
  input  logic [31:0]     cfg_wdata,
  output logic            cfg_rvalid,
  output logic [31:0]     cfg_rdata,
  input  logic            trans_req,
  input  logic [ADDR-3:0] trans_req_addr,
  output logic            trans_ack,
  output logic [61:0]     trans_ack_addr,
  output logic            trans_ack_64,
  output logic            trans_ack_err,
  output logic            busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMP, ST_ACK} state_t;

  state_t state_q, state_d;

  logic [ADDR-3:0]    base_q [WINDOWS];
  logic [ADDR-3:0]    mask_q [WINDOWS];
  logic [61:0]        tgt_q  [WINDOWS];
  logic [WINDOWS-1:0] en_q;

  logic [ADDR-3:0]    addr_q;
  logic [WINDOWS-1:0] hit_q, hit_d;
  logic               cfg_rvalid_q;
  logic [31:0]        cfg_rdata_q, cfg_rdata_d;
  logic               ack_q, ack64_q, ack64_d, err_q, err_d;
  logic [61:0]        ack_addr_q, ack_addr_d;

  logic cfg_acc, capture;

  assign busy       = (state_q != ST_IDLE);
  assign cfg_ready  = !busy;
  assign cfg_acc    = cfg_valid && cfg_ready;

  assign cfg_rvalid     = cfg_rvalid_q;
  assign cfg_rdata      = cfg_rdata_q;
  assign trans_ack      = ack_q;
  assign trans_ack_addr = ack_addr_q;
  assign trans_ack_64   = ack64_q;
  assign trans_ack_err  = err_q;

  // Capture is blocked during the ack cycle so a still-high trans_req is only seen one cycle later
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: if (trans_req && !ack_q && !cfg_acc) begin
        capture = 1'b1;
        state_d = ST_CMP;
      end
      ST_CMP:  state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    cfg_rdata_d = '0;
    for (int i = 0; i < WINDOWS; i++) begin
      if (cfg_win == WINB'(i)) begin
        case (cfg_reg)
          3'd0:    cfg_rdata_d[ADDR-1:2] = base_q[i];
          3'd1:    cfg_rdata_d[ADDR-1:2] = mask_q[i];
          3'd2:    cfg_rdata_d = {tgt_q[i][29:0], 2'b00};
          3'd3:    cfg_rdata_d = tgt_q[i][61:30];
          3'd4:    cfg_rdata_d = {31'd0, en_q[i]};
          default: cfg_rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WINDOWS; i++) begin
        base_q[i] <= '0;
        mask_q[i] <= '0;
        tgt_q[i]  <= '0;
      end
      en_q         <= '0;
      cfg_rvalid_q <= 1'b0;
      cfg_rdata_q  <= '0;
    end else begin
      cfg_rvalid_q <= cfg_acc && !cfg_write;
      if (cfg_acc && !cfg_write) cfg_rdata_q <= cfg_rdata_d;
      for (int i = 0; i < WINDOWS; i++) begin
        if (cfg_acc && cfg_write && cfg_win == WINB'(i)) begin
          case (cfg_reg)
            3'd0:    base_q[i]        <= cfg_wdata[ADDR-1:2];
            3'd1:    mask_q[i]        <= cfg_wdata[ADDR-1:2];
            3'd2:    tgt_q[i][29:0]   <= cfg_wdata[31:2];
            3'd3:    tgt_q[i][61:30]  <= cfg_wdata;
            3'd4:    en_q[i]          <= cfg_wdata[0];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WINDOWS; i++)
      hit_d[i] = en_q[i] && (((addr_q ^ base_q[i]) & mask_q[i]) == '0);
  end

  // Lowest-index hit wins; unmasked address bits come from the request
  always_comb begin
    logic            found;
    logic [61:0]     sel_tgt;
    logic [ADDR-3:0] sel_mask;
    found    = 1'b0;
    sel_tgt  = '0;
    sel_mask = '0;
    for (int i = 0; i < WINDOWS; i++) begin
      if (hit_q[i] && !found) begin
        found    = 1'b1;
        sel_tgt  = tgt_q[i];
        sel_mask = mask_q[i];
      end
    end
    ack_addr_d = '0;
    err_d      = 1'b0;
    if (found) begin
      ack_addr_d            = sel_tgt;
      ack_addr_d[ADDR-3:0]  = (sel_tgt[ADDR-3:0] & sel_mask) | (addr_q & ~sel_mask);
    end else if (PASSTHRU != 0) begin
      ack_addr_d = 62'(addr_q);
    end else begin
      err_d = 1'b1;
    end
    ack64_d = |ack_addr_d[61:30];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      hit_q      <= '0;
      ack_q      <= 1'b0;
      ack_addr_q <= '0;
      ack64_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (capture) addr_q <= trans_req_addr;
      if (state_q == ST_CMP) hit_q <= hit_d;
      if (state_q == ST_ACK) begin
        ack_addr_q <= ack_addr_d;
        ack64_q    <= ack64_d;
        err_q      <= err_d;
      end
      ack_q <= (state_q == ST_ACK);
    end
  end

endmodule
